// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch path: FSM state encoding and
// the program-counter geometry used by the ROM and the fetch unit.
package cpu_pkg;

    localparam int unsigned CPU_PC_WIDTH = 16;
    localparam int unsigned CPU_RESET_PC = 0;
    localparam int unsigned CPU_PROG_LEN = 55;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : cpu_pkg

// File: rtl/pc_fetch_unit_next_calc.sv
// Combinational next-PC selection: halt/stall/jump/branch/sequential priority,
// branch sign-extension and the end-of-program range check.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int unsigned PC_WIDTH = CPU_PC_WIDTH,
    parameter int unsigned PROG_LEN = CPU_PROG_LEN
) (
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic                i_stall,
    input  logic                i_halt,
    input  logic                i_jump_en,
    input  logic [PC_WIDTH-1:0] i_jump_target,
    input  logic                i_branch_taken,
    input  logic [7:0]          i_branch_offset,
    output logic [PC_WIDTH-1:0] o_next_pc,
    output logic                o_retire,
    output logic                o_finish,
    output logic                o_fault
);

    localparam logic [PC_WIDTH-1:0] LP_END = PC_WIDTH'(PROG_LEN);

    logic [PC_WIDTH-1:0] w_sext;
    logic [PC_WIDTH-1:0] w_branch_pc;
    logic [PC_WIDTH-1:0] w_seq_pc;
    logic                w_branch_wrap;

    assign w_sext      = {{(PC_WIDTH-8){i_branch_offset[7]}}, i_branch_offset};
    assign w_branch_pc = i_pc + w_sext;
    assign w_seq_pc    = i_pc + PC_WIDTH'(1);

    // A negative offset that yields a larger PC wrapped below zero; a positive
    // one that yields a smaller PC wrapped past the top of the address space.
    assign w_branch_wrap = i_branch_offset[7] ? (w_branch_pc > i_pc)
                                              : (w_branch_pc < i_pc);

    always_comb begin
        o_next_pc = i_pc;
        o_retire  = 1'b0;
        o_finish  = 1'b0;
        o_fault   = 1'b0;
        if (i_halt) begin
            o_retire = 1'b1;
            o_finish = 1'b1;
        end else if (i_stall) begin
            o_next_pc = i_pc;
        end else if (i_jump_en) begin
            o_next_pc = i_jump_target;
            o_retire  = 1'b1;
            if (i_jump_target >= LP_END) begin
                o_finish = 1'b1;
                o_fault  = 1'b1;
            end
        end else if (i_branch_taken) begin
            o_next_pc = w_branch_pc;
            o_retire  = 1'b1;
            if (w_branch_wrap || (w_branch_pc >= LP_END)) begin
                o_finish = 1'b1;
                o_fault  = 1'b1;
            end
        end else begin
            o_next_pc = w_seq_pc;
            o_retire  = 1'b1;
            o_finish  = (w_seq_pc >= LP_END);
        end
    end

endmodule : pc_next_calc

// File: rtl/pc_fetch_unit.sv
// Program counter and IDLE/RUN/DONE fetch sequencer feeding the instruction
// ROM address; also tracks the retired-instruction count and fault status.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PC_WIDTH = CPU_PC_WIDTH,
    parameter int unsigned RESET_PC = CPU_RESET_PC,
    parameter int unsigned PROG_LEN = CPU_PROG_LEN
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_stall,
    input  logic                i_branch_taken,
    input  logic [7:0]          i_branch_offset,
    input  logic                i_jump_en,
    input  logic [PC_WIDTH-1:0] i_jump_target,
    input  logic                i_halt,
    output logic [PC_WIDTH-1:0] o_pc_out,
    output logic                o_running,
    output logic                o_done,
    output logic                o_fault,
    output logic [15:0]         o_retired,
    output state_t              o_state
);

    localparam logic [PC_WIDTH-1:0] LP_RESET_PC = PC_WIDTH'(RESET_PC);

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [15:0]         r_retired;
    logic                r_fault;

    state_t              w_state_next;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [15:0]         w_retired_next;
    logic                w_fault_next;

    logic [PC_WIDTH-1:0] w_calc_pc;
    logic                w_calc_retire;
    logic                w_calc_finish;
    logic                w_calc_fault;

    pc_next_calc #(
        .PC_WIDTH (PC_WIDTH),
        .PROG_LEN (PROG_LEN)
    ) u_next_calc (
        .i_pc            (r_pc),
        .i_stall         (i_stall),
        .i_halt          (i_halt),
        .i_jump_en       (i_jump_en),
        .i_jump_target   (i_jump_target),
        .i_branch_taken  (i_branch_taken),
        .i_branch_offset (i_branch_offset),
        .o_next_pc       (w_calc_pc),
        .o_retire        (w_calc_retire),
        .o_finish        (w_calc_finish),
        .o_fault         (w_calc_fault)
    );

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_retired_next = r_retired;
        w_fault_next   = r_fault;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_next   = ST_RUN;
                    w_pc_next      = LP_RESET_PC;
                    w_retired_next = 16'd0;
                    w_fault_next   = 1'b0;
                end
            end
            ST_RUN: begin
                w_pc_next = w_calc_pc;
                // Count saturates rather than wrapping so long runs stay meaningful.
                if (w_calc_retire && (r_retired != 16'hFFFF)) begin
                    w_retired_next = r_retired + 16'd1;
                end
                if (w_calc_finish) begin
                    w_state_next = ST_DONE;
                    w_fault_next = w_calc_fault;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= LP_RESET_PC;
            r_retired <= 16'd0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_retired <= w_retired_next;
            r_fault   <= w_fault_next;
        end
    end

    assign o_pc_out  = r_pc;
    assign o_running = (r_state == ST_RUN);
    assign o_done    = (r_state == ST_DONE);
    assign o_fault   = r_fault;
    assign o_retired = r_retired;
    assign o_state   = r_state;

endmodule : pc_fetch_unit

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and fetch sequencer that drives the 16-bit `pc_in` of the 9-bit instruction ROM and so sets which instruction the decode/control stage sees each cycle. It holds the PC and a start/run/halt state machine. It applies stall, relative branch, absolute jump and halt requests from control. It reports completion and a retired-instruction count to the testbench.

## Interface
- `PC_WIDTH`, 16: width of the program counter. Matches the ROM address.
- `RESET_PC`, 0: PC value loaded on reset and on `start`.
- `PROG_LEN`, 55: first address past the program. Reaching it ends execution.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: one-cycle pulse. Begins execution from `RESET_PC`.
- `stall` input 1: hold the PC this cycle.
- `branch_taken` input 1: take a relative branch.
- `branch_offset` input 8: two's-complement offset (ROM `immediate`), relative to the current PC.
- `jump_en` input 1: take an absolute jump.
- `jump_target` input PC_WIDTH: absolute jump address.
- `halt` input 1: halt instruction decoded.
- `pc_out` output PC_WIDTH: registered PC. Connects to ROM `pc_in`.
- `running` output 1: high in RUN.
- `done` output 1: high in DONE. Sticky until `start` or reset.
- `fault` output 1: high if execution ended because the PC left [0, PROG_LEN) via branch or jump.
- `retired` output 16: count of instructions advanced past (PC updates while RUN and not stalled).

## Operation
- States: IDLE, RUN, DONE.
- Reset (`rst_n`=0 at an edge) sets state IDLE, `pc_out`=RESET_PC, `running`=0, `done`=0, `fault`=0, `retired`=0. Reset overrides every other input, including mid-RUN.
- IDLE: `start`=1 sets state RUN, `pc_out`=RESET_PC, `retired`=0, `fault`=0. Other inputs are ignored.
- RUN: next-PC priority per cycle, highest first:
  1. `halt`: go to DONE. PC is held. `retired`+1.
  2. `stall`: PC is held. `retired` is unchanged.
  3. `jump_en`: PC = `jump_target`.
  4. `branch_taken`: PC = PC + sign-extend(`branch_offset`), modulo 2^PC_WIDTH.
  5. Otherwise: PC = PC + 1.
- In cases 3–5, `retired` increments by 1 and saturates at 16'hFFFF.
- End of program: if the computed next PC is ≥ PROG_LEN, or a branch wrapped below 0:
  - load the next PC into `pc_out` and go to DONE;
  - set `fault`=1 only if the cause was a branch or jump;
  - sequential fall-through to exactly PROG_LEN is the normal finish, with `fault`=0.
- DONE: PC and `retired` are frozen. `start` restarts exactly as from IDLE.
- `start` asserted while in RUN is ignored.
- `branch_taken` with `jump_en` in the same cycle: the jump wins.
- `stall` with `halt` in the same cycle: the halt wins.

## Timing
- `pc_out` is registered. The ROM is combinational, so the instruction at `pc_out` is valid in the same cycle.
- Control inputs are sampled at the rising edge and refer to the instruction currently addressed. The effect appears on `pc_out` one cycle later.
- `start` → first fetch: `pc_out`=RESET_PC and `running`=1 in the cycle after the `start` edge.
- `done`, `running` and `fault` are registered and change on the same edge as the state.
- No combinational path from any input to any output.

## Structure
- Shared package `cpu_pkg`:
  - state enum (IDLE/RUN/DONE);
  - PC_WIDTH;
  - PROG_LEN.
- Sub-module `pc_next_calc`: combinational next-PC mux, sign-extend/add, range check.
- Top level: state register, PC register, `retired` counter.

## Test plan
- Reset then `start` with no control inputs for 60 cycles:
  - `pc_out` steps 0,1,…,54;
  - `pc_out`=55 with `done`=1 and `fault`=0 on the 55th edge after RUN entry;
  - `retired`=55.
- At PC=10, `branch_taken` with offset 8'hFC: next `pc_out`=6.
- At PC=6, offset 8'h05: next `pc_out`=11.
- At PC=3, `stall` for 3 cycles and then release:
  - `pc_out` holds 3 for 3 cycles, then 4;
  - `retired` is unchanged during the stall.
- At PC=2, `jump_en`=1 with target 20 and `branch_taken`=1 in the same cycle: `pc_out`=20.
- At PC=20, `jump_en` with target 100: `pc_out`=100, `done`=1, `fault`=1.
- At PC=1, branch offset 8'hF0: PC wraps, state goes to DONE with `fault`=1.
- `rst_n`=0 for one edge at PC=30 mid-RUN:
  - `pc_out`=0, state IDLE, `retired`=0;
  - a subsequent `start` restarts from 0.
- Also at PC=30 mid-RUN, `halt` with `stall` asserted together: DONE with PC held at 30.
